// File: rtl/mar_burst.sv
// mar_burst: memory address register with a burst address generator.
// Holds a base address, serves legacy single reads and issues strided
// bursts over a valid/ready handshake. mar_out is always driven.
// Optional feature macro: MAR_BOUNDS_CHK_EN adds lim_lo/lim_hi window
// checking and a sticky err output; without it addresses wrap freely.

module mar_burst #(
  parameter int AW = 13,
  parameter int LW = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_mar,
  input  logic          re_mar,
  input  logic [AW-1:0] mar_in,
  input  logic          burst_start,
  input  logic [LW-1:0] burst_len,
  input  logic [SW-1:0] stride,
  input  logic          dir,
  input  logic          burst_abort,
  input  logic          addr_rdy,
  output logic [AW-1:0] mar_out,
  output logic          addr_vld,
  output logic          busy,
  output logic          done
`ifdef MAR_BOUNDS_CHK_EN
  ,
  input  logic [AW-1:0] lim_lo,
  input  logic [AW-1:0] lim_hi,
  output logic          err
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [LW-1:0] CNT_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] CNT_ONE  = LW'(1);

  state_t        state_r, state_s;
  logic [AW-1:0] mar_r, mar_s;
  logic [AW-1:0] mar_out_r, mar_out_s;
  logic          addr_vld_r, addr_vld_s;
  logic          done_r, done_s;
  logic          busy_r;
  logic [LW-1:0] count_r, count_s;
  logic [SW-1:0] stride_r, stride_s;
  logic          dir_r, dir_s;
  logic [AW-1:0] base_s;
  logic [AW-1:0] step_s;
  logic          hs_s;
  logic          oob_s;
`ifdef MAR_BOUNDS_CHK_EN
  logic          err_r, err_s;
  logic [AW-1:0] chk_addr_s;
`endif

  // Next burst address; arithmetic wraps naturally at AW bits.
  function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] a,
                                               input logic [SW-1:0] s,
                                               input logic          d);
    logic [AW-1:0] s_ext;
    s_ext = AW'(s);
    if (d) begin
      return a - s_ext;
    end else begin
      return a + s_ext;
    end
  endfunction

`ifdef MAR_BOUNDS_CHK_EN
  // True when an address lies outside the inclusive [lo, hi] window.
  function automatic logic out_of_bounds(input logic [AW-1:0] a,
                                         input logic [AW-1:0] lo,
                                         input logic [AW-1:0] hi);
    return (a < lo) || (a > hi);
  endfunction
`endif

  // A same-cycle wr_mar feeds the burst base directly.
  assign base_s = wr_mar ? mar_in : mar_r;
  assign step_s = step_addr(mar_out_r, stride_r, dir_r);
  assign hs_s   = addr_vld_r & addr_rdy;

`ifdef MAR_BOUNDS_CHK_EN
  // Address that would be presented next, used only for the window check.
  always_comb begin
    chk_addr_s = mar_r;
    if (state_r == ST_BURST) begin
      chk_addr_s = step_s;
    end else if (burst_start) begin
      chk_addr_s = base_s;
    end else begin
      chk_addr_s = mar_r;
    end
  end

  assign oob_s = out_of_bounds(chk_addr_s, lim_lo, lim_hi);
`else
  assign oob_s = 1'b0;
`endif

  // Next-state and datapath decisions for the IDLE/BURST controller.
  always_comb begin
    state_s    = state_r;
    mar_s      = mar_r;
    mar_out_s  = mar_out_r;
    addr_vld_s = addr_vld_r;
    done_s     = 1'b0;
    count_s    = count_r;
    stride_s   = stride_r;
    dir_s      = dir_r;
`ifdef MAR_BOUNDS_CHK_EN
    err_s      = err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // A single-read valid lasts exactly one cycle.
        addr_vld_s = 1'b0;
        if (wr_mar) begin
          mar_s = mar_in;
`ifdef MAR_BOUNDS_CHK_EN
          err_s = 1'b0;
`endif
        end else begin
          mar_s = mar_r;
        end
        if (burst_start) begin
          if (burst_len == CNT_ZERO) begin
            // Empty burst: nothing is issued, completion still reported.
            done_s = 1'b1;
          end else if (oob_s) begin
            mar_s = base_s;
`ifdef MAR_BOUNDS_CHK_EN
            err_s = 1'b1;
`endif
          end else begin
            mar_out_s  = base_s;
            addr_vld_s = 1'b1;
            count_s    = burst_len;
            stride_s   = stride;
            dir_s      = dir;
            state_s    = ST_BURST;
          end
        end else if (re_mar) begin
          if (oob_s) begin
            mar_s = mar_r;
`ifdef MAR_BOUNDS_CHK_EN
            err_s = 1'b1;
`endif
          end else begin
            // Old MAR value is presented even if wr_mar loads a new one.
            mar_out_s  = mar_r;
            addr_vld_s = 1'b1;
          end
        end else begin
          mar_out_s = mar_out_r;
        end
      end
      ST_BURST: begin
        if (burst_abort) begin
          // Abort wins over a same-cycle handshake; MAR keeps the
          // first address the memory port has not accepted.
          addr_vld_s = 1'b0;
          mar_s      = mar_out_r;
          count_s    = CNT_ZERO;
          state_s    = ST_IDLE;
        end else if (hs_s) begin
          if (count_r > CNT_ONE) begin
            if (oob_s) begin
              addr_vld_s = 1'b0;
              mar_s      = step_s;
              count_s    = CNT_ZERO;
              state_s    = ST_IDLE;
`ifdef MAR_BOUNDS_CHK_EN
              err_s      = 1'b1;
`endif
            end else begin
              mar_out_s = step_s;
              count_s   = count_r - CNT_ONE;
            end
          end else begin
            // Last address accepted: MAR points past the burst.
            addr_vld_s = 1'b0;
            mar_s      = step_s;
            done_s     = 1'b1;
            count_s    = CNT_ZERO;
            state_s    = ST_IDLE;
          end
        end else begin
          // Memory port stalled: hold the presented address.
          mar_out_s  = mar_out_r;
          addr_vld_s = addr_vld_r;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        addr_vld_s = 1'b0;
        count_s    = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mar_r      <= {AW{1'b0}};
      mar_out_r  <= {AW{1'b0}};
      addr_vld_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      count_r    <= CNT_ZERO;
      stride_r   <= {SW{1'b0}};
      dir_r      <= 1'b0;
`ifdef MAR_BOUNDS_CHK_EN
      err_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      mar_r      <= mar_s;
      mar_out_r  <= mar_out_s;
      addr_vld_r <= addr_vld_s;
      done_r     <= done_s;
      busy_r     <= (state_s == ST_BURST);
      count_r    <= count_s;
      stride_r   <= stride_s;
      dir_r      <= dir_s;
`ifdef MAR_BOUNDS_CHK_EN
      err_r      <= err_s;
`endif
    end
  end

  assign mar_out  = mar_out_r;
  assign addr_vld = addr_vld_r;
  assign busy     = busy_r;
  assign done     = done_r;
`ifdef MAR_BOUNDS_CHK_EN
  assign err      = err_r;
`endif

endmodule

// File: tb/tb_mar_burst.sv
// Directed bench for mar_burst: expected addresses are queued when stimulus
// is applied and popped by a monitor on each accepted address.
// Covers MAR_BOUNDS_CHK_EN scenarios when that macro is defined.

module tb_mar_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_mar, re_mar, burst_start, dir, burst_abort, addr_rdy;
  logic [12:0] mar_in;
  logic [7:0]  burst_len;
  logic [3:0]  stride;
  logic [12:0] mar_out;
  logic        addr_vld, busy, done;
`ifdef MAR_BOUNDS_CHK_EN
  logic [12:0] lim_lo, lim_hi;
  logic        err;
`endif

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [12:0] exp_q[$];

  mar_burst #(.AW(13), .LW(8), .SW(4)) dut (
    .clk(clk), .rst(rst), .wr_mar(wr_mar), .re_mar(re_mar), .mar_in(mar_in),
    .burst_start(burst_start), .burst_len(burst_len), .stride(stride),
    .dir(dir), .burst_abort(burst_abort), .addr_rdy(addr_rdy),
    .mar_out(mar_out), .addr_vld(addr_vld), .busy(busy), .done(done)
`ifdef MAR_BOUNDS_CHK_EN
    , .lim_lo(lim_lo), .lim_hi(lim_hi), .err(err)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare every accepted address against the scoreboard.
  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst && addr_vld && (!busy || (addr_rdy && !burst_abort))) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_addr", 32'(mar_out), 32'hDEAD_0000);
      end else begin
        e = exp_q.pop_front();
        chk("addr", 32'(mar_out), 32'(e));
      end
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single_read(input logic [12:0] exp);
    exp_q.push_back(exp);
    re_mar = 1'b1;
    tick();
    re_mar = 1'b0;
    chk("rd_vld", 32'(addr_vld), 32'd1);
    tick();
    chk("rd_vld_clr", 32'(addr_vld), 32'd0);
  endtask

  // Load base and start in the same cycle, then scramble the sampled inputs.
  task automatic start_burst(input logic [12:0] base, input logic [7:0] len,
                             input logic [3:0] str, input logic d);
    mar_in = base; wr_mar = 1'b1; burst_start = 1'b1;
    burst_len = len; stride = str; dir = d;
    tick();
    wr_mar = 1'b0; burst_start = 1'b0;
    burst_len = 8'hFF; stride = 4'hF; dir = ~d; mar_in = 13'h0AAA;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int d0;
    logic [6:0] pat;
    rst = 1'b1; wr_mar = 1'b0; re_mar = 1'b0; burst_start = 1'b0;
    burst_len = 8'd0; stride = 4'd0; dir = 1'b0; burst_abort = 1'b0;
    addr_rdy = 1'b1; mar_in = 13'h0000;
`ifdef MAR_BOUNDS_CHK_EN
    lim_lo = 13'h0000; lim_hi = 13'h1FFF;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst_mar_out", 32'(mar_out), 32'd0);
    chk("rst_vld", 32'(addr_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Single read after load; addr_rdy is ignored.
    addr_rdy = 1'b0;
    mar_in = 13'h0100; wr_mar = 1'b1; tick(); wr_mar = 1'b0;
    single_read(13'h0100);
    // Same-cycle load and read presents the old value.
    mar_in = 13'h0200; wr_mar = 1'b1;
    single_read(13'h0100);
    wr_mar = 1'b0;
    single_read(13'h0200);

    // Basic burst with timing of first address and done.
    addr_rdy = 1'b1;
    exp_q.push_back(13'h0010); exp_q.push_back(13'h0012);
    exp_q.push_back(13'h0014); exp_q.push_back(13'h0016);
    start_burst(13'h0010, 8'd4, 4'd2, 1'b0);
    chk("b_first_vld", 32'(addr_vld), 32'd1);
    chk("b_first_addr", 32'(mar_out), 32'h0010);
    chk("b_busy", 32'(busy), 32'd1);
    tick(); tick(); tick();
    chk("b_done_early", 32'(done), 32'd0);
    tick();
    chk("b_done", 32'(done), 32'd1);
    chk("b_busy_end", 32'(busy), 32'd0);
    chk("b_vld_end", 32'(addr_vld), 32'd0);
    tick();
    chk("b_done_pulse", 32'(done), 32'd0);
    single_read(13'h0018);

    // Back-pressure pattern; control inputs while busy are ignored.
    pat = 7'b1011001;   // applied LSB first: 1,0,0,1,1,0,1
    exp_q.push_back(13'h0010); exp_q.push_back(13'h0012);
    exp_q.push_back(13'h0014); exp_q.push_back(13'h0016);
    start_burst(13'h0010, 8'd4, 4'd2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      addr_rdy = pat[i];
      if (i == 1) begin
        wr_mar = 1'b1; re_mar = 1'b1; burst_start = 1'b1; mar_in = 13'h0555;
      end
      tick();
      wr_mar = 1'b0; re_mar = 1'b0; burst_start = 1'b0;
      if (i == 2) begin
        chk("bp_hold_addr", 32'(mar_out), 32'h0012);
        chk("bp_hold_vld", 32'(addr_vld), 32'd1);
      end
    end
    chk("bp_done", 32'(done), 32'd1);
    addr_rdy = 1'b1;
    tick();
    single_read(13'h0018);

    // Wrap up and down.
    exp_q.push_back(13'h1FFE); exp_q.push_back(13'h1FFF); exp_q.push_back(13'h0000);
    start_burst(13'h1FFE, 8'd3, 4'd1, 1'b0);
    wait_done("wrap_up_done", 10);
    tick();
    exp_q.push_back(13'h0001); exp_q.push_back(13'h0000); exp_q.push_back(13'h1FFF);
    start_burst(13'h0001, 8'd3, 4'd1, 1'b1);
    wait_done("wrap_dn_done", 10);
    tick();
    single_read(13'h1FFE);

    // Zero-length burst and zero stride.
    start_burst(13'h0050, 8'd0, 4'd3, 1'b0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_vld", 32'(addr_vld), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    single_read(13'h0050);
    exp_q.push_back(13'h0040); exp_q.push_back(13'h0040); exp_q.push_back(13'h0040);
    start_burst(13'h0040, 8'd3, 4'd0, 1'b0);
    wait_done("stride0_done", 10);
    tick();
    single_read(13'h0040);

    // Abort after two handshakes, abort asserted together with ready.
    exp_q.push_back(13'h0020); exp_q.push_back(13'h0021);
    start_burst(13'h0020, 8'd5, 4'd1, 1'b0);
    tick(); tick();
    d0 = done_cnt;
    burst_abort = 1'b1;
    tick();
    burst_abort = 1'b0;
    chk("abort_vld", 32'(addr_vld), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    single_read(13'h0022);

    // Reset in the middle of a burst.
    start_burst(13'h0030, 8'd5, 4'd1, 1'b0);
    addr_rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_mar_out", 32'(mar_out), 32'd0);
    chk("mrst_vld", 32'(addr_vld), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    addr_rdy = 1'b1;
    single_read(13'h0000);

`ifdef MAR_BOUNDS_CHK_EN
    // Window violation stops the burst with a sticky error.
    lim_lo = 13'h0000; lim_hi = 13'h0013;
    d0 = done_cnt;
    exp_q.push_back(13'h0010); exp_q.push_back(13'h0012);
    start_burst(13'h0010, 8'd8, 4'd2, 1'b0);
    tick(); tick(); tick();
    chk("bnd_err", 32'(err), 32'd1);
    chk("bnd_vld", 32'(addr_vld), 32'd0);
    chk("bnd_busy", 32'(busy), 32'd0);
    chk("bnd_no_done", 32'(done_cnt - d0), 32'd0);
    tick();
    chk("bnd_err_sticky", 32'(err), 32'd1);
    mar_in = 13'h0005; wr_mar = 1'b1; tick(); wr_mar = 1'b0;
    chk("bnd_err_clr", 32'(err), 32'd0);
    lim_lo = 13'h0000; lim_hi = 13'h1FFF;
`endif

    tick(); tick(); tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
